msu_io_arbiter: RTL and testbench

MSU_IO_ARBITER -- requirements
Module: msu_io_arbiter

---
 rtl/msu_io_arbiter_pkg.sv | 38 +++
 rtl/msu_req_latch.sv | 50 +++++
 rtl/msu_io_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_msu_io_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/msu_io_arbiter_pkg.sv
// Shared MSU definitions: arbiter state encoding, channel identifiers,
// field widths and the grant-selection helper used by msu_io_arbiter.
package msu_io_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ISSUE      = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_XFER       = 2'd3
  } msu_state_t;

  localparam logic CH_AUDIO = 1'b0;
  localparam logic CH_DATA  = 1'b1;

  localparam int SECTOR_W = 22;
  localparam int RETRY_W  = 2;
  localparam int TMO_W    = 24;

  // Urgent audio wins outright; otherwise a tie goes to the channel that
  // was not granted last. Returns the winning channel id.
  function automatic logic pick_winner(input logic aud_valid,
                                       input logic dat_valid,
                                       input logic aud_urgent,
                                       input logic last_grant);
    logic win;
    if (aud_valid && aud_urgent) begin
      win = CH_AUDIO;
    end else if (aud_valid && dat_valid) begin
      win = (last_grant == CH_DATA) ? CH_AUDIO : CH_DATA;
    end else if (dat_valid) begin
      win = CH_DATA;
    end else begin
      win = CH_AUDIO;
    end
    return win;
  endfunction

endpackage

// File: rtl/msu_req_latch.sv
// Pending-request holder for one MSU client channel.
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   req, seek     request pulses from the client
//   sector        sector accompanying req/seek
//   consume       arbiter grants this entry this cycle
//   abort         client cancels any pending work
//   valid         an entry is pending
//   pend_seek     pending entry is a seek
//   pend_sector   pending sector
module msu_req_latch
  import msu_io_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                seek,
  input  logic [SECTOR_W-1:0] sector,
  input  logic                consume,
  input  logic                abort,
  output logic                valid,
  output logic                pend_seek,
  output logic [SECTOR_W-1:0] pend_sector
);

  // The old entry only contributes its seek flag if it is not being
  // granted away in this same cycle; otherwise the new pulse starts fresh.
  logic keep_s;
  assign keep_s = valid & ~consume;

  // Pending entry register: abort clears, a new pulse overwrites, a grant consumes.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid       <= 1'b0;
      pend_seek   <= 1'b0;
      pend_sector <= {SECTOR_W{1'b0}};
    end else if (abort) begin
      valid     <= 1'b0;
      pend_seek <= 1'b0;
    end else if (req || seek) begin
      valid       <= 1'b1;
      pend_seek   <= seek | (keep_s & pend_seek);
      pend_sector <= sector;
    end else if (consume) begin
      valid     <= 1'b0;
      pend_seek <= 1'b0;
    end
  end

endmodule

// File: rtl/msu_io_arbiter.sv
// Arbitrates the MSU audio and data clients onto the single HPS sector
// fetch interface, with start timeout, bounded retries and audio abort.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   aud_req/seek/sector/urgent/abort audio client requests and control
//   aud_ack, aud_wr                  audio transfer window and data strobe
//   dat_req/seek/sector              data client requests
//   dat_ack, dat_wr                  data transfer window and data strobe
//   io_data                          HPS word, wired straight to clients
//   hps_req/seek/chan/sector         request to HPS
//   hps_busy, hps_wr                 HPS streaming window and word strobe
//   io_error                         sticky: retries exhausted
module msu_io_arbiter
  import msu_io_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                aud_req,
  input  logic                aud_seek,
  input  logic [SECTOR_W-1:0] aud_sector,
  input  logic                aud_urgent,
  input  logic                aud_abort,
  output logic                aud_ack,
  output logic                aud_wr,
  input  logic                dat_req,
  input  logic                dat_seek,
  input  logic [SECTOR_W-1:0] dat_sector,
  output logic                dat_ack,
  output logic                dat_wr,
  input  logic [15:0]         io_data,
  output logic                hps_req,
  output logic                hps_seek,
  output logic                hps_chan,
  output logic [SECTOR_W-1:0] hps_sector,
  input  logic                hps_busy,
  input  logic                hps_wr,
  output logic                io_error
);

  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [TMO_W-1:0]   TMO_ONE   = TMO_W'(1);
  localparam logic [TMO_W-1:0]   TMO_MAX   = {TMO_W{1'b1}};
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);
  localparam logic [RETRY_W-1:0] RETRY_ONE = RETRY_W'(1);

  msu_state_t           state_r;
  logic                 last_grant_r;
  logic [RETRY_W-1:0]   retry_r;
  logic [TMO_W-1:0]     tmo_cnt_r;
  logic                 aud_mute_r;

  logic                 aud_valid_s, dat_valid_s;
  logic                 aud_pseek_s, dat_pseek_s;
  logic [SECTOR_W-1:0]  aud_psector_s, dat_psector_s;
  logic                 aud_avail_s;
  logic                 win_s;
  logic                 grant_s;
  logic                 aud_take_s, dat_take_s;
  logic                 aud_cancel_s;

  // io_data reaches the clients on their own wiring; the arbiter only
  // decides who may strobe it in, so the word itself is not used here.
  logic unused_io;
  assign unused_io = ^io_data;

  msu_req_latch aud_latch (
    .clk         (clk),
    .reset       (reset),
    .req         (aud_req),
    .seek        (aud_seek),
    .sector      (aud_sector),
    .consume     (aud_take_s),
    .abort       (aud_abort),
    .valid       (aud_valid_s),
    .pend_seek   (aud_pseek_s),
    .pend_sector (aud_psector_s)
  );

  msu_req_latch dat_latch (
    .clk         (clk),
    .reset       (reset),
    .req         (dat_req),
    .seek        (dat_seek),
    .sector      (dat_sector),
    .consume     (dat_take_s),
    .abort       (1'b0),
    .valid       (dat_valid_s),
    .pend_seek   (dat_pseek_s),
    .pend_sector (dat_psector_s)
  );

  // An audio entry being aborted this cycle must not win arbitration.
  assign aud_avail_s  = aud_valid_s & ~aud_abort;
  assign win_s        = pick_winner(aud_avail_s, dat_valid_s, aud_urgent, last_grant_r);
  assign grant_s      = (state_r == ST_IDLE) & (aud_avail_s | dat_valid_s);
  assign aud_take_s   = grant_s & (win_s == CH_AUDIO);
  assign dat_take_s   = grant_s & (win_s == CH_DATA);
  assign aud_cancel_s = (hps_chan == CH_AUDIO) & aud_abort;

  // Arbiter FSM with all client/HPS-facing outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      last_grant_r <= CH_DATA;
      retry_r      <= {RETRY_W{1'b0}};
      tmo_cnt_r    <= {TMO_W{1'b0}};
      aud_mute_r   <= 1'b0;
      hps_req      <= 1'b0;
      hps_seek     <= 1'b0;
      hps_chan     <= CH_AUDIO;
      hps_sector   <= {SECTOR_W{1'b0}};
      aud_ack      <= 1'b0;
      dat_ack      <= 1'b0;
      aud_wr       <= 1'b0;
      dat_wr       <= 1'b0;
      io_error     <= 1'b0;
    end else begin
      hps_req <= 1'b0;
      aud_wr  <= 1'b0;
      dat_wr  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_s) begin
            hps_chan     <= win_s;
            hps_seek     <= (win_s == CH_AUDIO) ? aud_pseek_s : dat_pseek_s;
            hps_sector   <= (win_s == CH_AUDIO) ? aud_psector_s : dat_psector_s;
            last_grant_r <= win_s;
            retry_r      <= {RETRY_W{1'b0}};
            hps_req      <= 1'b1;
            state_r      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          tmo_cnt_r <= {TMO_W{1'b0}};
          state_r   <= aud_cancel_s ? ST_IDLE : ST_WAIT_START;
        end
        ST_WAIT_START: begin
          if (aud_cancel_s) begin
            state_r <= ST_IDLE;
          end else if (hps_busy) begin
            aud_ack    <= (hps_chan == CH_AUDIO);
            dat_ack    <= (hps_chan == CH_DATA);
            aud_mute_r <= 1'b0;
            state_r    <= ST_XFER;
          end else if (tmo_cnt_r == TMO_LAST) begin
            // Re-issue the same fields until the retry budget is spent.
            if (retry_r < RETRY_LIM) begin
              retry_r <= retry_r + RETRY_ONE;
              hps_req <= 1'b1;
              state_r <= ST_ISSUE;
            end else begin
              io_error <= 1'b1;
              state_r  <= ST_IDLE;
            end
          end else if (tmo_cnt_r != TMO_MAX) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
          end
        end
        ST_XFER: begin
          if (!hps_busy) begin
            aud_ack    <= 1'b0;
            dat_ack    <= 1'b0;
            aud_mute_r <= 1'b0;
            state_r    <= ST_IDLE;
          end else begin
            // Once audio is aborted its strobes stay muted for the rest of
            // the sector, while ack holds until HPS finishes streaming.
            aud_wr <= hps_wr & (hps_chan == CH_AUDIO) & ~aud_abort & ~aud_mute_r;
            dat_wr <= hps_wr & (hps_chan == CH_DATA);
            if (aud_cancel_s) begin
              aud_mute_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msu_io_arbiter.sv
// Directed self-checking bench for msu_io_arbiter (TIMEOUT_CYC=16, MAX_RETRY=3).
module tb_msu_io_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        aud_req = 1'b0, aud_seek = 1'b0, aud_urgent = 1'b0, aud_abort = 1'b0;
  logic [21:0] aud_sector = 22'd0;
  logic        aud_ack, aud_wr;
  logic        dat_req = 1'b0, dat_seek = 1'b0;
  logic [21:0] dat_sector = 22'd0;
  logic        dat_ack, dat_wr;
  logic [15:0] io_data = 16'd0;
  logic        hps_req, hps_seek, hps_chan;
  logic [21:0] hps_sector;
  logic        hps_busy = 1'b0, hps_wr = 1'b0;
  logic        io_error;

  always #5 clk = ~clk;

  msu_io_arbiter #(.TIMEOUT_CYC(16), .MAX_RETRY(3)) dut (
    .clk(clk), .reset(reset),
    .aud_req(aud_req), .aud_seek(aud_seek), .aud_sector(aud_sector),
    .aud_urgent(aud_urgent), .aud_abort(aud_abort), .aud_ack(aud_ack), .aud_wr(aud_wr),
    .dat_req(dat_req), .dat_seek(dat_seek), .dat_sector(dat_sector),
    .dat_ack(dat_ack), .dat_wr(dat_wr), .io_data(io_data),
    .hps_req(hps_req), .hps_seek(hps_seek), .hps_chan(hps_chan), .hps_sector(hps_sector),
    .hps_busy(hps_busy), .hps_wr(hps_wr), .io_error(io_error)
  );

  int checks = 0;
  int errors = 0;

  // Event counters sampled on the falling edge, away from DUT updates.
  int cyc = 0, req_cnt = 0, aud_wr_cnt = 0, dat_wr_cnt = 0, aud_ack_cnt = 0;
  int req_times[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (hps_req) begin
      req_cnt <= req_cnt + 1;
      req_times.push_back(cyc);
    end
    if (aud_wr)  aud_wr_cnt  <= aud_wr_cnt + 1;
    if (dat_wr)  dat_wr_cnt  <= dat_wr_cnt + 1;
    if (aud_ack) aud_ack_cnt <= aud_ack_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (hps_req !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check_val("req_seen", 32'(hps_req), 32'd1);
  endtask

  task automatic pulse(input logic a, input logic d, input int a_sec, input int d_sec);
    aud_req = a; aud_sector = 22'(a_sec);
    dat_req = d; dat_sector = 22'(d_sec);
    tick();
    aud_req = 1'b0; dat_req = 1'b0;
  endtask

  // kind: 1 aud_req, 2 dat_req, 3 dat_seek, 4 aud_req(sec)+dat_req(sec+10)
  task automatic inject(input int kind, input int sec);
    case (kind)
      1: begin aud_req = 1'b1; aud_sector = 22'(sec); end
      2: begin dat_req = 1'b1; dat_sector = 22'(sec); end
      3: begin dat_seek = 1'b1; dat_sector = 22'(sec); end
      4: begin
        aud_req = 1'b1; aud_sector = 22'(sec);
        dat_req = 1'b1; dat_sector = 22'(sec + 10);
      end
      default: ;
    endcase
  endtask

  // Called with the DUT in ISSUE: busy rises 3 cycles later, then one
  // strobe per cycle; returns two cycles after busy falls.
  task automatic run_xfer(input logic exp_chan, input int words, input int abort_at,
                          input int i1, input int k1, input int s1,
                          input int i2, input int k2, input int s2);
    repeat (3) tick();
    hps_busy = 1'b1;
    tick();
    check_val("ack_latency", 32'({aud_ack, dat_ack}), (exp_chan == 1'b0) ? 32'd2 : 32'd1);
    for (int i = 0; i < words; i++) begin
      hps_wr = 1'b1;
      io_data = 16'(i * 3);
      aud_req = 1'b0; dat_req = 1'b0; dat_seek = 1'b0;
      if (i == i1) inject(k1, s1);
      if (i == i2) inject(k2, s2);
      if (abort_at >= 0 && i >= abort_at) aud_abort = 1'b1;
      tick();
    end
    hps_wr = 1'b0; aud_req = 1'b0; dat_req = 1'b0; dat_seek = 1'b0;
    hps_busy = 1'b0; aud_abort = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, aw0, dw0, ak0, qb;

    // Reset state
    repeat (3) tick();
    check_val("reset_outs", 32'({hps_req, hps_seek, hps_chan, aud_ack, dat_ack, aud_wr, dat_wr, io_error}), 32'd0);
    check_val("reset_sector", 32'(hps_sector), 32'd0);
    reset = 1'b0;
    tick();
    check_val("idle_outs", 32'({hps_req, aud_ack, dat_ack, io_error}), 32'd0);

    // Simultaneous pair after reset: audio first. A second pair arrives
    // during the audio transfer; last grant is audio, so data goes first.
    pulse(1'b1, 1'b1, 10, 20);
    wait_req();
    check_val("pair1_chan", 32'(hps_chan), 32'd0);
    check_val("pair1_sector", 32'(hps_sector), 32'd10);
    run_xfer(1'b0, 4, -1, 1, 4, 11, -1, 0, 0);
    wait_req();
    check_val("pair2_first_chan", 32'(hps_chan), 32'd1);
    check_val("pair2_first_sector", 32'(hps_sector), 32'd21);
    dw0 = dat_wr_cnt; aw0 = aud_wr_cnt;
    run_xfer(1'b1, 6, -1, -1, 0, 0, -1, 0, 0);
    check_val("pair2_dat_wr", 32'(dat_wr_cnt - dw0), 32'd6);
    check_val("pair2_aud_wr", 32'(aud_wr_cnt - aw0), 32'd0);
    wait_req();
    check_val("pair2_second_chan", 32'(hps_chan), 32'd0);
    check_val("pair2_second_sector", 32'(hps_sector), 32'd11);
    run_xfer(1'b0, 3, -1, -1, 0, 0, -1, 0, 0);

    // Urgent audio beats data even though audio was granted last.
    aud_urgent = 1'b1;
    pulse(1'b1, 1'b1, 31, 30);
    wait_req();
    aud_urgent = 1'b0;
    check_val("urgent_chan", 32'(hps_chan), 32'd0);
    check_val("urgent_sector", 32'(hps_sector), 32'd31);
    run_xfer(1'b0, 3, -1, -1, 0, 0, -1, 0, 0);
    wait_req();
    check_val("urgent_then_data", 32'(hps_chan), 32'd1);
    run_xfer(1'b1, 3, -1, -1, 0, 0, -1, 0, 0);

    // Full 512-word audio sector; a data seek then data req queue meanwhile.
    r0 = req_cnt;
    pulse(1'b1, 1'b0, 5, 0);
    wait_req();
    check_val("sector5_chan", 32'(hps_chan), 32'd0);
    check_val("sector5_sector", 32'(hps_sector), 32'd5);
    check_val("sector5_seek", 32'(hps_seek), 32'd0);
    aw0 = aud_wr_cnt; dw0 = dat_wr_cnt; ak0 = aud_ack_cnt;
    run_xfer(1'b0, 512, -1, 10, 3, 7, 20, 2, 8);
    check_val("sector5_aud_wr", 32'(aud_wr_cnt - aw0), 32'd512);
    check_val("sector5_dat_wr", 32'(dat_wr_cnt - dw0), 32'd0);
    check_val("sector5_ack_cycles", 32'(aud_ack_cnt - ak0), 32'd513);
    check_val("sector5_req_count", 32'(req_cnt - r0), 32'd1);
    wait_req();
    check_val("seek_or_chan", 32'(hps_chan), 32'd1);
    check_val("seek_or_seek", 32'(hps_seek), 32'd1);
    check_val("seek_or_sector", 32'(hps_sector), 32'd8);
    run_xfer(1'b1, 2, -1, -1, 0, 0, -1, 0, 0);

    // Abort during audio transfer after 100 words; queued audio req dropped.
    r0 = req_cnt;
    pulse(1'b1, 1'b0, 40, 0);
    wait_req();
    aw0 = aud_wr_cnt; ak0 = aud_ack_cnt;
    run_xfer(1'b0, 200, 100, 50, 1, 41, -1, 0, 0);
    check_val("abort_aud_wr", 32'(aud_wr_cnt - aw0), 32'd100);
    check_val("abort_ack_cycles", 32'(aud_ack_cnt - ak0), 32'd201);
    repeat (10) tick();
    check_val("abort_pending_cleared", 32'(req_cnt - r0), 32'd1);

    // Start timeout: busy never rises -> 4 requests 17 cycles apart, then error.
    qb = req_times.size();
    check_val("error_before_timeout", 32'(io_error), 32'd0);
    pulse(1'b0, 1'b1, 0, 50);
    repeat (100) tick();
    check_val("timeout_req_count", 32'(req_times.size() - qb), 32'd4);
    if (req_times.size() >= qb + 4) begin
      for (int k = 1; k < 4; k++)
        check_val("timeout_gap", 32'(req_times[qb + k] - req_times[qb + k - 1]), 32'd17);
    end
    check_val("timeout_io_error", 32'(io_error), 32'd1);

    // Arbiter back in IDLE serves a new request; error stays sticky.
    pulse(1'b1, 1'b0, 60, 0);
    wait_req();
    check_val("post_error_sector", 32'(hps_sector), 32'd60);
    check_val("error_sticky", 32'(io_error), 32'd1);

    // Reset in the middle of an audio transfer.
    repeat (3) tick();
    hps_busy = 1'b1;
    tick();
    check_val("pre_reset_ack", 32'(aud_ack), 32'd1);
    hps_wr = 1'b1;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    check_val("midxfer_reset_outs", 32'({hps_req, hps_seek, hps_chan, aud_ack, dat_ack, aud_wr, dat_wr, io_error}), 32'd0);
    check_val("midxfer_reset_sector", 32'(hps_sector), 32'd0);
    reset = 1'b0;
    aw0 = aud_wr_cnt; dw0 = dat_wr_cnt;
    repeat (10) tick();
    check_val("post_reset_aud_wr", 32'(aud_wr_cnt - aw0), 32'd0);
    check_val("post_reset_dat_wr", 32'(dat_wr_cnt - dw0), 32'd0);
    check_val("post_reset_ack", 32'({aud_ack, dat_ack}), 32'd0);
    hps_wr = 1'b0;
    hps_busy = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
